// File: rtl/reset_seq_pkg.sv
// Reset sequencer shared definitions.
// State encoding and default timing parameters.
package reset_seq_pkg;

    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_LOCK_FILTER  = 4;
    localparam int unsigned DEF_ICN_DELAY    = 16;
    localparam int unsigned DEF_PERIPH_DELAY = 16;
    localparam int unsigned DEF_CNT_W        = 8;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        ICN_WAIT = 3'd1,
        PER_WAIT = 3'd2,
        RUN      = 3'd3,
        SW_RST   = 3'd4,
        DRAIN    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer.
// Output rises on the STAGES-th clock edge after arst_n rises.
module reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift a constant one through the chain once reset lifts.
    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(1);
    end

    // Chain clears immediately whenever arst_n drops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer.
// Releases interconnect then peripherals; handles software peripheral resets.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_FILTER  = DEF_LOCK_FILTER,
    parameter int unsigned ICN_DELAY    = DEF_ICN_DELAY,
    parameter int unsigned PERIPH_DELAY = DEF_PERIPH_DELAY,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       slowest_sync_clk,
    input  logic       ext_reset_in,
    input  logic       dcm_locked,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       interconnect_aresetn,
    output logic       peripheral_aresetn,
    output logic       peripheral_reset,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] ICN_LAST = CNT_W'(ICN_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIPH_DELAY - 1);

    logic             rst_n_sync;
    logic             lock_meta_q;
    logic             lock_q;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             icn_q, icn_d;
    logic             per_q, per_d;
    logic             prst_q, prst_d;
    logic             ack_q, ack_d;
    logic             arm_q, arm_d;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (slowest_sync_clk),
        .arst_n     (ext_reset_in),
        .rst_n_sync (rst_n_sync)
    );

    // Two-flop lock synchronizer, cleared alongside the external reset.
    always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
        if (!ext_reset_in) begin
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            lock_meta_q <= dcm_locked;
            lock_q      <= lock_meta_q;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        icn_d   = icn_q;
        per_d   = per_q;
        ack_d   = 1'b0;
        arm_d   = arm_q | ~sw_rst_req;
        unique case (state_q)
            HOLD: begin
                icn_d = 1'b0;
                per_d = 1'b0;
                if (!lock_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LF_LAST) begin
                    state_d = ICN_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ICN_WAIT: begin
                if (!lock_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    icn_d   = 1'b0;
                    per_d   = 1'b0;
                end else if (cnt_q == ICN_LAST) begin
                    state_d = PER_WAIT;
                    cnt_d   = '0;
                    icn_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PER_WAIT: begin
                if (!lock_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    icn_d   = 1'b0;
                    per_d   = 1'b0;
                end else if (cnt_q == PER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    per_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_q) begin
                    state_d = DRAIN;
                    per_d   = 1'b0;
                end else if (sw_rst_req && arm_q) begin
                    state_d = SW_RST;
                    per_d   = 1'b0;
                    arm_d   = 1'b0;
                end
            end
            SW_RST: begin
                if (!lock_q) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    per_d   = 1'b1;
                    ack_d   = 1'b1;
                    arm_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                cnt_d = '0;
                per_d = 1'b0;
                if (icn_q) begin
                    icn_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                icn_d   = 1'b0;
                per_d   = 1'b0;
            end
        endcase
        prst_d = ~per_d;
    end

    // Sequencer state and outputs, forced to reset values asynchronously.
    always_ff @(posedge slowest_sync_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            icn_q   <= 1'b0;
            per_q   <= 1'b0;
            prst_q  <= 1'b1;
            ack_q   <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            icn_q   <= icn_d;
            per_q   <= per_d;
            prst_q  <= prst_d;
            ack_q   <= ack_d;
            arm_q   <= arm_d;
        end
    end

    assign sw_rst_ack           = ack_q;
    assign interconnect_aresetn = icn_q;
    assign peripheral_aresetn   = per_q;
    assign peripheral_reset     = prst_q;
    assign seq_state            = state_q;

endmodule
